// File: rtl/dro_pulse_scheduler.sv
// Serialises write/destructive-read requests onto a bank of DRO cells, spacing
// set/reset toggles by guard windows and checking read results against a shadow copy.
module dro_pulse_scheduler #(
  parameter int N_CELLS     = 4,
  parameter int SEP_CYCLES  = 3,
  parameter int OUT_WAIT    = 2,
  parameter int INIT_CYCLES = 8,
  localparam int IW = $clog2(N_CELLS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_req,
  input  logic [IW-1:0]      wr_idx,
  output logic               wr_ack,
  input  logic               rd_req,
  input  logic [IW-1:0]      rd_idx,
  output logic               rd_ack,
  output logic               rd_data,
  output logic [N_CELLS-1:0] dro_set,
  output logic [N_CELLS-1:0] dro_reset,
  input  logic [N_CELLS-1:0] dro_out,
  output logic               busy,
  output logic               err
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ISSUE, S_GUARD, S_WAIT_OUT, S_DONE
  } state_t;

  state_t             state;
  logic [15:0]        cnt;
  logic [N_CELLS-1:0] shadow;
  logic [N_CELLS-1:0] mask;
  logic               op_write, skip, bad_idx, ref_bit, prev_bit, rr_write;

  logic               pick_write;
  logic [IW-1:0]      g_idx;
  logic [N_CELLS-1:0] g_mask;
  logic               g_shadow, g_out, diff, hit;

  // An out-of-range index decodes to an all-zero mask, which doubles as the validity flag.
  always_comb begin
    pick_write = wr_req && (!rd_req || rr_write);
    g_idx      = pick_write ? wr_idx : rd_idx;
    g_mask     = '0;
    for (int unsigned i = 0; i < N_CELLS; i++)
      g_mask[i] = (g_idx == IW'(i));
    g_shadow = |(shadow & g_mask);
    g_out    = |(dro_out & g_mask);
    diff     = (|(dro_out & mask)) ^ ref_bit;
    hit      = rd_data | diff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      cnt       <= '0;
      dro_set   <= '0;
      dro_reset <= '0;
      shadow    <= '0;
      mask      <= '0;
      wr_ack    <= 1'b0;
      rd_ack    <= 1'b0;
      rd_data   <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b1;
      rr_write  <= 1'b1;
      op_write  <= 1'b0;
      skip      <= 1'b0;
      bad_idx   <= 1'b0;
      ref_bit   <= 1'b0;
      prev_bit  <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      rd_ack <= 1'b0;
      case (state)
        S_INIT: begin
          if (cnt == 16'(INIT_CYCLES - 1)) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        // The pulse is launched on the grant edge so the ISSUE cycle presents it and
        // the reference is the DRO output strictly before the toggle.
        S_IDLE: begin
          if (wr_req || rd_req) begin
            state    <= S_ISSUE;
            busy     <= 1'b1;
            op_write <= pick_write;
            mask     <= g_mask;
            bad_idx  <= ~|g_mask;
            prev_bit <= g_shadow;
            ref_bit  <= g_out;
            rd_data  <= 1'b0;
            if (wr_req && rd_req) rr_write <= ~pick_write;
            if (pick_write) begin
              skip    <= g_shadow || ~|g_mask;
              dro_set <= g_shadow ? dro_set : (dro_set ^ g_mask);
              shadow  <= shadow | g_mask;
            end else begin
              skip      <= ~|g_mask;
              dro_reset <= dro_reset ^ g_mask;
              shadow    <= shadow & ~g_mask;
            end
          end
        end
        S_ISSUE: begin
          cnt <= '0;
          if (skip) begin
            state  <= S_DONE;
            wr_ack <= op_write;
            rd_ack <= ~op_write;
            err    <= err | bad_idx;
          end else begin
            state <= S_GUARD;
          end
        end
        S_GUARD: begin
          if (cnt == 16'(SEP_CYCLES - 1)) begin
            cnt <= '0;
            if (op_write) begin
              state  <= S_DONE;
              wr_ack <= 1'b1;
            end else begin
              state <= S_WAIT_OUT;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_WAIT_OUT: begin
          if (diff) rd_data <= 1'b1;
          if (cnt == 16'(OUT_WAIT - 1)) begin
            cnt    <= '0;
            state  <= S_DONE;
            rd_ack <= 1'b1;
            if (hit != prev_bit) err <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_dro_pulse_scheduler.sv
// Directed bench for dro_pulse_scheduler with a behavioural DRO cell model
// (stored bit, out toggles one cycle after a reset pulse on a stored 1).
module tb_dro_pulse_scheduler;

  localparam int N    = 4;
  localparam int SEP  = 3;
  localparam int OW   = 2;
  localparam int INIT = 8;
  localparam int WLAT = 1 + SEP + 1;
  localparam int RLAT = 1 + SEP + OW + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_req = 1'b0, rd_req = 1'b0;
  logic [1:0]   wr_idx = '0, rd_idx = '0;
  logic         wr_ack, rd_ack, rd_data, busy, err;
  logic [N-1:0] dro_set, dro_reset;
  logic [N-1:0] dro_out;
  logic [N-1:0] stuck = '0;

  int checks = 0;
  int errors = 0;

  dro_pulse_scheduler #(
    .N_CELLS(N), .SEP_CYCLES(SEP), .OUT_WAIT(OW), .INIT_CYCLES(INIT)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_idx(wr_idx), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack), .rd_data(rd_data),
    .dro_set(dro_set), .dro_reset(dro_reset), .dro_out(dro_out),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // DRO cell model, evaluated on the falling edge away from DUT updates.
  logic [N-1:0] set_q, res_q, stored, pend;
  always @(negedge clk) begin
    if (rst) begin
      dro_out = '0; set_q = '0; res_q = '0; stored = '0; pend = '0;
    end else begin
      dro_out = dro_out ^ pend;
      pend = '0;
      for (int i = 0; i < N; i++) begin
        if (dro_set[i] != set_q[i]) stored[i] = 1'b1;
        if (dro_reset[i] != res_q[i]) begin
          if (stored[i] && !stuck[i]) pend[i] = 1'b1;
          stored[i] = 1'b0;
        end
      end
      set_q = dro_set;
      res_q = dro_reset;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_op(input bit wr, input int idx, input int drop_at,
                       output int lat, output int nset, output int nres,
                       output int first_tog, output int tmask,
                       output int rdd, output int errv, output int wrong);
    logic [N-1:0] ps, pr, d;
    logic [1:0]   ix;
    bit           acked;
    ix = idx[1:0];
    ps = dro_set; pr = dro_reset;
    lat = 0; nset = 0; nres = 0; first_tog = 0; tmask = 0;
    rdd = 0; errv = 0; wrong = 0; acked = 0;
    wr_idx = ix; rd_idx = ix; wr_req = wr; rd_req = !wr;
    while (!acked && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      d = (dro_set ^ ps) | (dro_reset ^ pr);
      nset += $countones(dro_set ^ ps);
      nres += $countones(dro_reset ^ pr);
      if (d != '0 && first_tog == 0) first_tog = lat;
      tmask |= int'(d);
      ps = dro_set; pr = dro_reset;
      if (wr ? rd_ack : wr_ack) wrong = 1;
      if (wr ? wr_ack : rd_ack) begin
        acked = 1; rdd = int'(rd_data); errv = int'(err);
      end
      if (lat == drop_at) begin
        wr_req = 0; rd_req = 0; wr_idx = ~ix; rd_idx = ~ix;
      end
    end
    wr_req = 0; rd_req = 0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit wr; int idx; int lat; int nset; int nres; int rdd; int errv; bit stk;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, nset, nres, ft, tm, rdd, ev, wrong, exp_mask;
    int seq, nacks, cyc, last_t, mingap, nbusy, nack_rst;
    logic [N-1:0] ps, pr;

    vecs[0] = '{1, 1, WLAT, 1, 0, 0, 0, 0};
    vecs[1] = '{0, 1, RLAT, 0, 1, 1, 0, 0};
    vecs[2] = '{0, 0, RLAT, 0, 1, 0, 0, 0};
    vecs[3] = '{1, 3, WLAT, 1, 0, 0, 0, 0};
    vecs[4] = '{1, 3, 2,    0, 0, 0, 0, 0};
    vecs[5] = '{0, 3, RLAT, 0, 1, 1, 0, 0};
    vecs[6] = '{1, 2, 2,    0, 0, 0, 0, 0};
    vecs[7] = '{0, 2, RLAT, 0, 1, 0, 1, 1};
    vecs[8] = '{1, 0, WLAT, 1, 0, 0, 1, 0};
    vecs[9] = '{0, 0, RLAT, 0, 1, 1, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_set", int'(dro_set), 0);
    chk("rst_reset", int'(dro_reset), 0);
    chk("rst_acks", int'({wr_ack, rd_ack, rd_data, err}), 0);
    chk("rst_busy", int'(busy), 1);

    // Request present the moment reset releases: held off by the INIT window.
    @(negedge clk); rst = 0;
    do_op(1, 2, 0, lat, nset, nres, ft, tm, rdd, ev, wrong);
    chk("init_first_toggle", ft, INIT + 1);
    chk("init_ack_lat", lat, INIT + WLAT);
    chk("init_set_mask", tm, 4);
    chk("init_nset", nset, 1);

    foreach (vecs[k]) begin
      stuck = vecs[k].stk ? (N'(1) << vecs[k].idx) : '0;
      do_op(vecs[k].wr, vecs[k].idx, 1, lat, nset, nres, ft, tm, rdd, ev, wrong);
      stuck = '0;
      exp_mask = (vecs[k].nset + vecs[k].nres > 0) ? (1 << vecs[k].idx) : 0;
      chk($sformatf("v%0d_lat", k), lat, vecs[k].lat);
      chk($sformatf("v%0d_nset", k), nset, vecs[k].nset);
      chk($sformatf("v%0d_nres", k), nres, vecs[k].nres);
      chk($sformatf("v%0d_mask", k), tm, exp_mask);
      chk($sformatf("v%0d_first_tog", k), ft, (exp_mask != 0) ? 1 : 0);
      chk($sformatf("v%0d_rd_data", k), rdd, vecs[k].rdd);
      chk($sformatf("v%0d_err", k), ev, vecs[k].errv);
      chk($sformatf("v%0d_wrong_ack", k), wrong, 0);
    end

    // Contested requests: alternate W,R,W,R with guard-spaced pulses.
    wr_idx = 0; rd_idx = 0; wr_req = 1; rd_req = 1;
    seq = 0; nacks = 0; cyc = 0; last_t = -100; mingap = 1000;
    ps = dro_set; pr = dro_reset;
    while (nacks < 4 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (((dro_set ^ ps) | (dro_reset ^ pr)) != '0) begin
        if (cyc - last_t < mingap) mingap = cyc - last_t;
        last_t = cyc;
      end
      ps = dro_set; pr = dro_reset;
      if (wr_ack) begin seq = seq * 2 + 1; nacks++; end
      if (rd_ack) begin seq = seq * 2; nacks++; end
    end
    wr_req = 0; rd_req = 0;
    @(posedge clk); #1;
    chk("rr_acks", nacks, 4);
    chk("rr_order", seq, 10);
    chk("rr_gap_ok", int'(mingap >= SEP + 1), 1);
    chk("err_sticky", int'(err), 1);

    // Reset asserted while a write sits in GUARD.
    @(negedge clk); wr_idx = 1; wr_req = 1;
    @(posedge clk); #1; wr_req = 0;
    repeat (2) @(posedge clk);
    #1; rst = 1; #1;
    chk("abort_set", int'(dro_set), 0);
    chk("abort_reset", int'(dro_reset), 0);
    chk("abort_busy", int'(busy), 1);
    chk("abort_err", int'(err), 0);
    nack_rst = 0;
    repeat (3) begin
      @(posedge clk); #1;
      nack_rst += int'(wr_ack) + int'(rd_ack);
    end
    @(negedge clk); rst = 0;
    nbusy = 0;
    for (int c = 0; c < INIT; c++) begin
      @(posedge clk); #1;
      nbusy += int'(busy);
      nack_rst += int'(wr_ack) + int'(rd_ack);
    end
    chk("abort_no_ack", nack_rst, 0);
    chk("init_busy_cycles", nbusy, INIT - 1);
    do_op(1, 1, 1, lat, nset, nres, ft, tm, rdd, ev, wrong);
    chk("post_rst_w1_lat", lat, WLAT);
    chk("post_rst_w1_nset", nset, 1);
    do_op(1, 2, 1, lat, nset, nres, ft, tm, rdd, ev, wrong);
    chk("post_rst_w2_lat", lat, WLAT);
    chk("post_rst_w2_nset", nset, 1);
    chk("post_rst_err", ev, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
